// File: rtl/multi_input_adder_stage.sv
// N-input unsigned adder stage with 2-phase bundled-data handshakes and a result FIFO.
// Optional macro ADDER_SATURATE_EN clamps narrow results instead of wrapping.
module multi_input_adder_stage #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         l_req,
  output logic                         l_ack,
  input  logic [N_IN*WIDTH-1:0]        l_data,
  output logic                         r_req,
  input  logic                         r_ack,
  output logic [OUT_WIDTH-1:0]         r_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         sat_flag
);

  localparam int unsigned FW = WIDTH + $clog2(N_IN);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t               state;
  logic                 l_req_s;
  logic                 r_ack_s;
  logic [FW-1:0]        sum_full;
  logic [OUT_WIDTH-1:0] push_val;
  logic                 clamp;
  logic                 push;
  logic                 pop;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [OUT_WIDTH-1:0] mem [DEPTH];

  // Handshake synchronisers; bypassed when both sides share this clock.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign l_req_s = l_req;
      assign r_ack_s = r_ack;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] l_sync;
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          l_sync <= '0;
          r_sync <= '0;
        end else begin
          l_sync[0] <= l_req;
          r_sync[0] <= r_ack;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            l_sync[i] <= l_sync[i-1];
            r_sync[i] <= r_sync[i-1];
          end
        end
      end
      assign l_req_s = l_sync[SYNC_STAGES-1];
      assign r_ack_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Full-precision sum of all zero-extended channels.
  always_comb begin
    sum_full = '0;
    for (int i = 0; i < N_IN; i++) begin
      sum_full = sum_full + FW'(l_data[i*WIDTH +: WIDTH]);
    end
  end

  generate
    if (OUT_WIDTH >= FW) begin : g_wide
      assign push_val = OUT_WIDTH'(sum_full);
      assign clamp    = 1'b0;
    end else begin : g_narrow
`ifdef ADDER_SATURATE_EN
      localparam logic [FW-1:0] MAX_OUT = FW'((64'd1 << OUT_WIDTH) - 64'd1);
      assign clamp    = (sum_full > MAX_OUT);
      assign push_val = clamp ? '1 : OUT_WIDTH'(sum_full);
`else
      assign clamp    = 1'b0;
      assign push_val = OUT_WIDTH'(sum_full);
`endif
    end
  endgenerate

  // A full FIFO stalls even if the head is popped this cycle.
  assign push = (l_req_s != l_ack) && (fifo_count < CW'(DEPTH));
  assign pop  = (state == IDLE) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      l_ack      <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        l_ack    <= ~l_ack;
        sat_flag <= sat_flag | clamp;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output handshake FSM; r_data holds from launch until the matching ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      r_req  <= 1'b0;
      r_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            r_data <= mem[rd_ptr];
            r_req  <= ~r_req;
            state  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (r_ack_s == r_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
